tcm_port_arbiter: RTL and testbench

Shares one single-port synchronous TCM (ITCM or DTCM instance) between two requesters. Port A is the CPU-side AHB-to-SRAM bridge and has priority. Port B is a secondary master (boot loader or DMA) that uses idle cycles, with a starvation guarantee. The block sits between the bridge and the TCM macro, one instance per TCM.

---
 rtl/tcm_arb_pkg.sv | 23 ++
 rtl/tcm_arb_starve_cnt.sv | 41 ++++
 rtl/tcm_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_tcm_port_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcm_arb_pkg.sv
// Shared encodings for the TCM port arbiter: FSM states, source selects and
// the replay hold register layout.
package tcm_arb_pkg;

  localparam int TCM_AW = 17;

  localparam logic [1:0] ST_NORM    = 2'd0;
  localparam logic [1:0] ST_FORCE_B = 2'd1;
  localparam logic [1:0] ST_REPLAY  = 2'd2;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_A    = 2'd1;
  localparam logic [1:0] SEL_HOLD = 2'd2;
  localparam logic [1:0] SEL_B    = 2'd3;

  // The hold address is TCM_AW wide, so the arbiter's AW must equal TCM_AW.
  typedef struct packed {
    logic [TCM_AW-1:0] addr;
    logic [3:0]        wen;
    logic [31:0]       wdata;
  } hold_t;

endpackage

// File: rtl/tcm_arb_starve_cnt.sv
// Saturating count of consecutive denied port-B cycles. limit_next flags that
// the count reaches STARVE_LIMIT at the next edge, so the forced slot lands on
// the cycle right after the last permitted denial.
module tcm_arb_starve_cnt #(
  parameter int STARVE_LIMIT = 8,
  parameter int CW           = 4
) (
  input  logic          sysclk,
  input  logic          RSTn,
  input  logic          b_req,
  input  logic          b_gnt,
  output logic [CW-1:0] cnt,
  output logic          limit_next
);

  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (!b_req || b_gnt) begin
      cnt_next = '0;
    end else if (cnt_reg != LIMIT) begin
      cnt_next = cnt_reg + CW'(1);
    end
  end

  assign limit_next = (cnt_next == LIMIT);
  assign cnt        = cnt_reg;

  always_ff @(posedge sysclk or negedge RSTn) begin
    if (!RSTn) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/tcm_port_arbiter.sv
// Shares one single-port TCM between the CPU bridge (port A, priority) and a
// secondary master (port B) that gets idle cycles plus a forced starvation slot.
module tcm_port_arbiter
  import tcm_arb_pkg::*;
#(
  parameter int AW           = TCM_AW,
  parameter int STARVE_LIMIT = 8,
  parameter int CW           = 4
) (
  input  logic          sysclk,
  input  logic          RSTn,
  input  logic          a_cs,
  input  logic [AW-1:0] a_addr,
  input  logic [3:0]    a_wen,
  input  logic [31:0]   a_wdata,
  output logic [31:0]   a_rdata,
  output logic          a_stall,
  input  logic          b_req,
  input  logic [AW-1:0] b_addr,
  input  logic [3:0]    b_wen,
  input  logic [31:0]   b_wdata,
  output logic          b_gnt,
  output logic [31:0]   b_rdata,
  output logic          b_rvalid,
  output logic          sram_cs,
  output logic [AW-1:0] sram_addr,
  output logic [3:0]    sram_wen,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata,
  output logic          arb_err
);

  logic [1:0]    state_reg;
  logic [1:0]    state_next;
  logic [1:0]    sel;
  hold_t         hold_reg;
  logic          a_stall_reg;
  logic          b_rvalid_reg;
  logic          arb_err_reg;
  logic [CW-1:0] cnt;
  logic          force_next;

  tcm_arb_starve_cnt #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CW           (CW)
  ) u_starve_cnt (
    .sysclk     (sysclk),
    .RSTn       (RSTn),
    .b_req      (b_req),
    .b_gnt      (b_gnt),
    .cnt        (cnt),
    .limit_next (force_next)
  );

  // Source selection; gated by RSTn so the TCM sees nothing while reset is held.
  always_comb begin
    sel        = SEL_NONE;
    b_gnt      = 1'b0;
    state_next = state_reg;
    if (RSTn) begin
      case (state_reg)
        ST_REPLAY: begin
          sel        = SEL_HOLD;
          state_next = ST_NORM;
        end
        ST_FORCE_B: begin
          b_gnt      = 1'b1;
          sel        = b_req ? SEL_B : SEL_NONE;
          state_next = a_cs ? ST_REPLAY : ST_NORM;
        end
        default: begin
          if (a_cs) begin
            sel = SEL_A;
          end else if (b_req) begin
            sel   = SEL_B;
            b_gnt = 1'b1;
          end
          if (b_req && force_next) begin
            state_next = ST_FORCE_B;
          end
        end
      endcase
    end
  end

  always_comb begin
    sram_cs    = 1'b0;
    sram_addr  = '0;
    sram_wen   = 4'b0;
    sram_wdata = 32'b0;
    case (sel)
      SEL_A: begin
        sram_cs    = 1'b1;
        sram_addr  = a_addr;
        sram_wen   = a_wen;
        sram_wdata = a_wdata;
      end
      SEL_HOLD: begin
        sram_cs    = 1'b1;
        sram_addr  = hold_reg.addr;
        sram_wen   = hold_reg.wen;
        sram_wdata = hold_reg.wdata;
      end
      SEL_B: begin
        sram_cs    = 1'b1;
        sram_addr  = b_addr;
        sram_wen   = b_wen;
        sram_wdata = b_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sysclk or negedge RSTn) begin
    if (!RSTn) begin
      state_reg    <= ST_NORM;
      hold_reg     <= '0;
      a_stall_reg  <= 1'b0;
      b_rvalid_reg <= 1'b0;
      arb_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      a_stall_reg  <= (state_next == ST_REPLAY);
      b_rvalid_reg <= b_req && b_gnt && (b_wen == 4'b0);
      // A live access during a stall is dropped by the mux above; only flag it.
      if (a_cs && a_stall_reg) begin
        arb_err_reg <= 1'b1;
      end
      if (state_reg == ST_FORCE_B && a_cs) begin
        hold_reg <= '{addr: a_addr, wen: a_wen, wdata: a_wdata};
      end
    end
  end

  assign a_rdata  = sram_rdata;
  assign b_rdata  = sram_rdata;
  assign a_stall  = a_stall_reg;
  assign b_rvalid = b_rvalid_reg;
  assign arb_err  = arb_err_reg;

endmodule

// File: tb/tb_tcm_port_arbiter.sv
// Bench for tcm_port_arbiter: behavioural TCM, vector table for single-cycle
// arbitration, hand sequences for forced slots, replay, protocol error and reset.
module tb_tcm_port_arbiter;

  localparam int AW    = 17;
  localparam int LIMIT = 8;
  localparam int CW    = 4;

  logic          sysclk = 1'b0;
  logic          RSTn   = 1'b0;
  logic          a_cs = 1'b0, b_req = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [3:0]    a_wen = '0, b_wen = '0;
  logic [31:0]   a_wdata = '0, b_wdata = '0;
  logic [31:0]   a_rdata, b_rdata, sram_wdata;
  logic [31:0]   sram_rdata = '0;
  logic          a_stall, b_gnt, b_rvalid, sram_cs, arb_err;
  logic [AW-1:0] sram_addr;
  logic [3:0]    sram_wen;

  always #5 sysclk = ~sysclk;

  tcm_port_arbiter #(.AW(AW), .STARVE_LIMIT(LIMIT), .CW(CW)) dut (
    .sysclk(sysclk), .RSTn(RSTn),
    .a_cs(a_cs), .a_addr(a_addr), .a_wen(a_wen), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_stall(a_stall),
    .b_req(b_req), .b_addr(b_addr), .b_wen(b_wen), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .sram_cs(sram_cs), .sram_addr(sram_addr), .sram_wen(sram_wen),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .arb_err(arb_err)
  );

  // Single-port TCM with one-cycle registered read and byte write enables.
  logic [31:0] mem [0:255];
  always @(posedge sysclk) begin
    if (sram_cs) begin
      if (sram_wen == 4'b0) sram_rdata <= mem[sram_addr[7:0]];
      else for (int k = 0; k < 4; k++)
        if (sram_wen[k]) mem[sram_addr[7:0]][8*k +: 8] <= sram_wdata[8*k +: 8];
    end
  end

  typedef struct { int due; bit is_b; logic [31:0] data; } sb_t;
  sb_t sb_q[$];
  int n_chk = 0, n_fail = 0, cyc = 0;

  typedef struct {
    int a_cs, a_addr, a_wen, a_wdata, b_req, b_addr, b_wen, b_wdata;
    int e_cs, e_addr, e_wen, e_gnt, e_cnt, e_rd;
  } vec_t;
  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input int ac, input int aa, input int aw, input int ad,
                       input int br, input int ba, input int bw, input int bd);
    a_cs = 1'(ac); a_addr = AW'(aa); a_wen = 4'(aw); a_wdata = 32'(ad);
    b_req = 1'(br); b_addr = AW'(ba); b_wen = 4'(bw); b_wdata = 32'(bd);
    $display("cyc %0d: rstn=%0b a_cs=%0b a_addr=%h a_wen=%h b_req=%0b b_addr=%h b_wen=%h",
             cyc, RSTn, a_cs, a_addr, a_wen, b_req, b_addr, b_wen);
  endtask

  task automatic expect_rd(input bit is_b, input int lat, input logic [31:0] d);
    sb_q.push_back('{cyc + lat, is_b, d});
  endtask

  // Samples at the falling edge; retires every scoreboard entry due this cycle.
  task automatic sample();
    bit b_due;
    @(negedge sysclk);
    b_due = 1'b0;
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].due == cyc) begin
        if (sb_q[i].is_b) begin
          b_due = 1'b1;
          chk("b_rvalid", 32'(b_rvalid), 32'd1);
          chk("b_rdata", b_rdata, sb_q[i].data);
        end else begin
          chk("a_rdata", a_rdata, sb_q[i].data);
        end
        sb_q.delete(i);
      end else if (sb_q[i].due < cyc) begin
        chk("sb_late", 32'(cyc), 32'(sb_q[i].due));
        sb_q.delete(i);
      end
    end
    if (!b_due) chk("b_rvalid_idle", 32'(b_rvalid), 32'd0);
  endtask

  task automatic adv();
    @(posedge sysclk);
    #1;
    cyc++;
  endtask

  task automatic idle_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    adv();
  endtask

  // LIMIT cycles of A reads against a held B request; B must stay denied.
  task automatic starve(input int ba, input int bw, input int bd);
    for (int i = 0; i < LIMIT; i++) begin
      drive(1, 'h60 + i, 0, 0, 1, ba, bw, bd);
      sample();
      chk($sformatf("starve%0d b_gnt", i), 32'(b_gnt), 32'd0);
      chk($sformatf("starve%0d sram_addr", i), 32'(sram_addr), 32'('h60 + i));
      expect_rd(1'b0, 1, 32'(32'hA000_0000 + i));
      adv();
    end
  endtask

  function automatic vec_t mk(int ac, int aa, int aw, int ad, int br, int ba, int bw, int bd,
                              int ecs, int ea, int ew, int eg, int ec, int erd);
    vec_t v;
    v = '{ac, aa, aw, ad, br, ba, bw, bd, ecs, ea, ew, eg, ec, erd};
    return v;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem['h10] = 32'hDEADBEEF;
    mem['h04] = 32'h0BADF00D;
    mem['h20] = 32'h11223344;
    mem['h30] = 32'h55667788;
    mem['h40] = 32'hCAFEF00D;
    for (int i = 0; i < 16; i++) mem['h60 + i] = 32'hA000_0000 + i;

    //         a_cs addr wen wdata        b_req addr wen wdata       cs addr  wen gnt cnt rd
    vecs[0]  = mk(0, 'h00, 0, 0,           0, 'h00, 0, 0,             0, 'h00, 0, 0, 0, 0);
    vecs[1]  = mk(0, 'h00, 0, 0,           1, 'h10, 0, 0,             1, 'h10, 0, 1, 0, 'hDEADBEEF);
    vecs[2]  = mk(1, 'h04, 0, 0,           1, 'h10, 0, 0,             1, 'h04, 0, 0, 0, 'h0BADF00D);
    vecs[3]  = mk(0, 'h00, 0, 0,           0, 'h00, 0, 0,             0, 'h00, 0, 0, 1, 0);
    vecs[4]  = mk(0, 'h00, 0, 0,           1, 'h50, 15, 'h12345678,   1, 'h50, 15, 1, 0, 0);
    vecs[5]  = mk(1, 'h50, 0, 0,           0, 'h00, 0, 0,             1, 'h50, 0, 0, 0, 'h12345678);
    vecs[6]  = mk(1, 'h50, 1, 'hAA,        0, 'h00, 0, 0,             1, 'h50, 1, 0, 0, 0);
    vecs[7]  = mk(0, 'h00, 0, 0,           1, 'h50, 0, 0,             1, 'h50, 0, 1, 0, 'h123456AA);
    vecs[8]  = mk(1, 'h50, 0, 0,           1, 'h50, 8, 'hEE000000,    1, 'h50, 0, 0, 0, 'h123456AA);
    vecs[9]  = mk(0, 'h00, 0, 0,           1, 'h50, 8, 'hEE000000,    1, 'h50, 8, 1, 1, 0);
    vecs[10] = mk(1, 'h50, 0, 0,           0, 'h00, 0, 0,             1, 'h50, 0, 0, 0, 'hEE3456AA);

    // Reset state, with live requests present to show the mux is gated.
    drive(1, 'h1234, 15, 'h5A5A5A5A, 1, 'h0321, 15, 'hA5A5A5A5);
    sample();
    chk("rst sram_cs", 32'(sram_cs), 32'd0);
    chk("rst sram_addr", 32'(sram_addr), 32'd0);
    chk("rst sram_wen", 32'(sram_wen), 32'd0);
    chk("rst sram_wdata", sram_wdata, 32'd0);
    chk("rst b_gnt", 32'(b_gnt), 32'd0);
    chk("rst a_stall", 32'(a_stall), 32'd0);
    chk("rst arb_err", 32'(arb_err), 32'd0);
    adv();
    RSTn = 1'b1;

    for (int v = 0; v < 11; v++) begin
      drive(vecs[v].a_cs, vecs[v].a_addr, vecs[v].a_wen, vecs[v].a_wdata,
            vecs[v].b_req, vecs[v].b_addr, vecs[v].b_wen, vecs[v].b_wdata);
      sample();
      chk($sformatf("v%0d sram_cs", v), 32'(sram_cs), 32'(vecs[v].e_cs));
      chk($sformatf("v%0d sram_addr", v), 32'(sram_addr), 32'(vecs[v].e_addr));
      chk($sformatf("v%0d sram_wen", v), 32'(sram_wen), 32'(vecs[v].e_wen));
      chk($sformatf("v%0d b_gnt", v), 32'(b_gnt), 32'(vecs[v].e_gnt));
      chk($sformatf("v%0d a_stall", v), 32'(a_stall), 32'd0);
      chk($sformatf("v%0d cnt", v), 32'(dut.cnt), 32'(vecs[v].e_cnt));
      if (vecs[v].e_cs != 0 && vecs[v].e_wen == 0)
        expect_rd(vecs[v].e_gnt != 0, 1, 32'(vecs[v].e_rd));
      adv();
    end
    idle_cycle();

    // Starvation: forced B on cycle LIMIT+1, stalled A read replayed next.
    starve('h10, 0, 0);
    drive(1, 'h68, 0, 0, 1, 'h10, 0, 0);
    sample();
    chk("force b_gnt", 32'(b_gnt), 32'd1);
    chk("force sram_addr", 32'(sram_addr), 32'h10);
    chk("force a_stall", 32'(a_stall), 32'd0);
    expect_rd(1'b1, 1, 32'hDEADBEEF);
    expect_rd(1'b0, 2, 32'hA000_0008);
    adv();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    chk("replay a_stall", 32'(a_stall), 32'd1);
    chk("replay sram_cs", 32'(sram_cs), 32'd1);
    chk("replay sram_addr", 32'(sram_addr), 32'h68);
    chk("replay b_gnt", 32'(b_gnt), 32'd0);
    adv();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    chk("post a_stall", 32'(a_stall), 32'd0);
    chk("post cnt", 32'(dut.cnt), 32'd0);
    adv();

    // Replayed partial write, then readback.
    starve('h10, 0, 0);
    drive(1, 'h20, 2, 'h0000AB00, 1, 'h10, 0, 0);
    sample();
    chk("wforce b_gnt", 32'(b_gnt), 32'd1);
    expect_rd(1'b1, 1, 32'hDEADBEEF);
    adv();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    chk("wreplay a_stall", 32'(a_stall), 32'd1);
    chk("wreplay sram_addr", 32'(sram_addr), 32'h20);
    chk("wreplay sram_wen", 32'(sram_wen), 32'h2);
    chk("wreplay sram_wdata", sram_wdata, 32'h0000AB00);
    adv();
    drive(1, 'h20, 0, 0, 0, 0, 0, 0);
    sample();
    chk("wread a_stall", 32'(a_stall), 32'd0);
    expect_rd(1'b0, 1, 32'h1122AB44);
    adv();
    idle_cycle();
    chk("pre-err arb_err", 32'(arb_err), 32'd0);

    // Illegal A access during the stall: dropped, arb_err sticks.
    starve('h10, 0, 0);
    drive(1, 'h68, 0, 0, 1, 'h10, 0, 0);
    sample();
    expect_rd(1'b1, 1, 32'hDEADBEEF);
    expect_rd(1'b0, 2, 32'hA000_0008);
    adv();
    drive(1, 'h30, 15, 'hFFFFFFFF, 0, 0, 0, 0);
    sample();
    chk("illegal a_stall", 32'(a_stall), 32'd1);
    chk("illegal sram_addr", 32'(sram_addr), 32'h68);
    chk("illegal sram_wen", 32'(sram_wen), 32'd0);
    adv();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    chk("err set", 32'(arb_err), 32'd1);
    adv();
    drive(1, 'h30, 0, 0, 0, 0, 0, 0);
    sample();
    expect_rd(1'b0, 1, 32'h55667788);
    adv();
    idle_cycle();
    chk("err sticky", 32'(arb_err), 32'd1);

    // Reset asserted during REPLAY: pending write to 0x40 must never issue.
    starve('h70, 15, 'h77777777);
    drive(1, 'h40, 15, 'h00000000, 1, 'h70, 15, 'h77777777);
    sample();
    chk("rforce b_gnt", 32'(b_gnt), 32'd1);
    adv();
    RSTn = 1'b0;
    drive(1, 'h10, 0, 0, 1, 'h10, 0, 0);
    sample();
    chk("rreplay sram_cs", 32'(sram_cs), 32'd0);
    chk("rreplay a_stall", 32'(a_stall), 32'd0);
    chk("rreplay b_gnt", 32'(b_gnt), 32'd0);
    chk("rreplay arb_err", 32'(arb_err), 32'd0);
    adv();
    idle_cycle();
    RSTn = 1'b1;
    drive(0, 0, 0, 0, 1, 'h40, 0, 0);
    sample();
    chk("rel b_gnt", 32'(b_gnt), 32'd1);
    chk("rel sram_addr", 32'(sram_addr), 32'h40);
    chk("rel cnt", 32'(dut.cnt), 32'd0);
    expect_rd(1'b1, 1, 32'hCAFEF00D);
    adv();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    chk("rel a_stall", 32'(a_stall), 32'd0);
    adv();
    idle_cycle();

    chk("sb_pending", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
